// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: parity modes, FSM encoding and a
// constant-time clog2 usable in port and parameter widths.
package uart_rx_fifo_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PAR       = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop happens in
// the same cycle, and a pop while empty is ignored.
module sync_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [clog2(DEPTH):0]    count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-of-3 mid-bit sampling, optional parity, 1 or 2
// stop bits, and a receive FIFO drained by rd_en.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 64,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        UART_RX,
    input  logic                        rd_en,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    output logic                        fifo_full,
    output logic [clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overrun_err,
    output rx_state_e                   state_dbg
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam int IDX_W = clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] SAMP0    = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] SAMP1    = CNT_W'(CLKS_PER_BIT/2);
    localparam logic [CNT_W-1:0] DECIDE   = CNT_W'(CLKS_PER_BIT/2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e             state, state_n;
    logic                  rx_meta, rx_s;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [IDX_W-1:0]      bit_idx, bit_idx_n;
    logic                  stop_idx, stop_idx_n;
    logic [DATA_BITS-1:0]  shift, shift_n;
    logic                  par_bad, par_bad_n;
    logic                  stop_bad, stop_bad_n;
    logic                  s0, s1;
    logic                  sample_bit, decide, parity_exp, frame_now;
    logic                  push, perr_p, ferr_p, ovr_p;
    logic                  fifo_empty;

    assign state_dbg = state;

    // Synchroniser presets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_s    <= rx_meta;
        end
    end

    assign sample_bit = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign decide     = (cnt == DECIDE);
    assign parity_exp = (PARITY == PARITY_ODD) ? ~(^shift) : ^shift;
    assign frame_now  = stop_bad | ~sample_bit;

    always_comb begin
        state_n    = state;
        cnt_n      = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        shift_n    = shift;
        par_bad_n  = par_bad;
        stop_bad_n = stop_bad;
        push       = 1'b0;
        perr_p     = 1'b0;
        ferr_p     = 1'b0;
        ovr_p      = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n      = '0;
                par_bad_n  = 1'b0;
                stop_bad_n = 1'b0;
                if (!rx_s) state_n = ST_START;
            end
            ST_START: begin
                if (decide) begin
                    if (sample_bit) state_n = ST_IDLE;
                    else begin
                        state_n   = ST_DATA;
                        bit_idx_n = '0;
                    end
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_n = {sample_bit, shift[DATA_BITS-1:1]};
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        state_n    = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
                        stop_idx_n = 1'b0;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (decide) begin
                    par_bad_n  = (sample_bit != parity_exp);
                    state_n    = ST_STOP;
                    stop_idx_n = 1'b0;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        // Returning to IDLE at mid-stop lets a gapless next start bit be caught.
                        if (frame_now) begin
                            ferr_p  = 1'b1;
                            state_n = ST_WAIT_IDLE;
                        end else if (par_bad) begin
                            perr_p  = 1'b1;
                            state_n = ST_IDLE;
                        end else if (fifo_full && !rd_en) begin
                            ovr_p   = 1'b1;
                            state_n = ST_IDLE;
                        end else begin
                            push    = 1'b1;
                            state_n = ST_IDLE;
                        end
                    end else begin
                        stop_bad_n = frame_now;
                        stop_idx_n = 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                cnt_n = '0;
                if (rx_s) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            shift       <= '0;
            par_bad     <= 1'b0;
            stop_bad    <= 1'b0;
            s0          <= 1'b1;
            s1          <= 1'b1;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            stop_idx    <= stop_idx_n;
            shift       <= shift_n;
            par_bad     <= par_bad_n;
            stop_bad    <= stop_bad_n;
            if (cnt == SAMP0) s0 <= rx_s;
            if (cnt == SAMP1) s1 <= rx_s;
            parity_err  <= perr_p;
            frame_err   <= ferr_p;
            overrun_err <= ovr_p;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd_en),
        .din   (shift),
        .dout  (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rx_valid = ~fifo_empty;

endmodule
